// File: rtl/sd_arb_pkg.sv
// Shared types and widths for the SD block-interface request arbiter.
package sd_arb_pkg;

   localparam int LBA_W = 32;
   localparam int BUF_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      XFER,
      RELEASE
   } arb_state_t;

endpackage

// File: rtl/sd_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending index at or after rr_ptr, wrapping modulo NREQ.
module rr_pick
   import sd_arb_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int IDX_W = 1
) (
   input  logic [NREQ-1:0]  pend,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);

   logic [NREQ-1:0] rot;
   logic [IDX_W:0]  sum;

   // Rotate so bit 0 is the requester at rr_ptr, then take the lowest set bit.
   always_comb begin
      rot   = NREQ'({pend, pend} >> rr_ptr);
      valid = 1'b0;
      idx   = '0;
      sum   = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (!valid && rot[k]) begin
            valid = 1'b1;
            sum   = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NREQ))
               sum = sum - (IDX_W+1)'(NREQ);
            idx = sum[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/sd_req_arbiter.sv
// Shares one SD block interface between NREQ track-buffer requesters, one 512-byte block per grant,
// round-robin; ack, buffer write strobe and buffer read data are routed to the granted requester only.
module sd_req_arbiter
   import sd_arb_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int IDX_W = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ*LBA_W-1:0]  req_lba,
   input  logic [NREQ-1:0]        req_rd,
   input  logic [NREQ-1:0]        req_wr,
   output logic [NREQ-1:0]        req_ack,
   output logic [NREQ-1:0]        req_buff_wr,
   input  logic [NREQ*BUF_W-1:0]  req_buff_din,
   output logic [LBA_W-1:0]       sd_lba,
   output logic                   sd_rd,
   output logic                   sd_wr,
   input  logic                   sd_ack,
   input  logic                   sd_buff_wr,
   output logic [BUF_W-1:0]       sd_buff_din,
   output logic [IDX_W-1:0]       grant,
   output logic                   active
);

   arb_state_t state, state_nxt;

   logic [NREQ-1:0]  pend;
   logic             pick_valid;
   logic [IDX_W-1:0] pick_idx;
   logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
   logic             old_ack;

   logic [LBA_W-1:0] sd_lba_nxt;
   logic             sd_rd_nxt, sd_wr_nxt, active_nxt;
   logic [IDX_W-1:0] grant_nxt;

   logic [LBA_W-1:0] lba_arr [NREQ];
   logic [BUF_W-1:0] din_arr [NREQ];

   always_comb begin
      for (int unsigned i = 0; i < NREQ; i++) begin
         lba_arr[i] = req_lba[LBA_W*i +: LBA_W];
         din_arr[i] = req_buff_din[BUF_W*i +: BUF_W];
      end
   end

   assign pend = req_rd | req_wr;

   rr_pick #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .pend   (pend),
      .rr_ptr (rr_ptr),
      .valid  (pick_valid),
      .idx    (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         sd_lba  <= '0;
         sd_rd   <= 1'b0;
         sd_wr   <= 1'b0;
         grant   <= '0;
         active  <= 1'b0;
         rr_ptr  <= '0;
         old_ack <= 1'b0;
      end else begin
         state   <= state_nxt;
         sd_lba  <= sd_lba_nxt;
         sd_rd   <= sd_rd_nxt;
         sd_wr   <= sd_wr_nxt;
         grant   <= grant_nxt;
         active  <= active_nxt;
         rr_ptr  <= rr_ptr_nxt;
         old_ack <= sd_ack;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_valid) state_nxt = ISSUE;
         ISSUE:   if (sd_ack) state_nxt = XFER;
         XFER:    if (old_ack && !sd_ack) state_nxt = RELEASE;
         RELEASE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // active drops on entry to RELEASE so the spare cycle is visibly idle to every requester.
   always_comb begin
      sd_lba_nxt = sd_lba;
      sd_rd_nxt  = sd_rd;
      sd_wr_nxt  = sd_wr;
      grant_nxt  = grant;
      active_nxt = active;
      rr_ptr_nxt = rr_ptr;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               grant_nxt  = pick_idx;
               sd_lba_nxt = lba_arr[pick_idx];
               sd_wr_nxt  = req_wr[pick_idx];
               sd_rd_nxt  = ~req_wr[pick_idx];
               active_nxt = 1'b1;
            end
         end
         ISSUE: begin
            if (sd_ack) begin
               sd_rd_nxt = 1'b0;
               sd_wr_nxt = 1'b0;
            end
         end
         XFER: begin
            if (old_ack && !sd_ack) begin
               active_nxt = 1'b0;
               rr_ptr_nxt = (grant == IDX_W'(NREQ-1)) ? '0 : grant + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      for (int unsigned i = 0; i < NREQ; i++) begin
         req_ack[i]     = sd_ack & active & (grant == IDX_W'(i));
         req_buff_wr[i] = sd_buff_wr & active & (grant == IDX_W'(i));
      end
   end

   assign sd_buff_din = din_arr[grant];

endmodule
